pulse_frame_checker: RTL and testbench

Downstream consumer of the single-trigger pulse generator. Samples the generator's `y_out` and checks that every frame is exactly `HI_LEN` high cycles followed by at least `GAP_LEN` low cycles. Flags each good frame and each malformed frame with one-cycle pulses, and keeps saturating frame and error counts for status readout.

---
 rtl/pulse_frame_pkg.sv | 25 ++
 rtl/pulse_frame_checker_sat_counter.sv | 40 ++++
 rtl/pulse_frame_checker.sv | 197 +++++++++++++++++++
 tb/tb_pulse_frame_checker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_frame_pkg.sv
// pulse_frame_pkg
// Shared definitions for the pulse generator / frame checker pair:
//   - state encodings of the frame checker FSM
//   - default frame shape (high-run length and minimum gap length), which
//     both the generator and the checker take from here so they stay in step.
package pulse_frame_pkg;

  // Encodings for the frame checker FSM states.
  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_HIGH_ENC    = 2'd1;
  localparam logic [1:0] ST_GAP_ENC     = 2'd2;
  localparam logic [1:0] ST_RECOVER_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_HIGH    = ST_HIGH_ENC,
    ST_GAP     = ST_GAP_ENC,
    ST_RECOVER = ST_RECOVER_ENC
  } pf_state_t;

  // Default frame shape: HI_LEN high cycles, then at least GAP_LEN low cycles.
  localparam int DEF_HI_LEN  = 3;
  localparam int DEF_GAP_LEN = 2;

endpackage

// File: rtl/pulse_frame_checker_sat_counter.sv
// sat_counter
// Saturating up-counter used for the frame checker status counters.
// Ports:
//   clk   in  1  rising-edge clock
//   reset in  1  synchronous active-high reset, clears q
//   clr   in  1  synchronous clear; takes priority over inc
//   inc   in  1  count enable; ignored once q is all-ones
//   q     out W  registered count value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE  = W'(1);

  logic [W-1:0] q_r;

  // Count register: clear beats increment, and the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= CNT_ZERO;
    end else if (clr) begin
      q_r <= CNT_ZERO;
    end else if (inc && (q_r != CNT_MAX)) begin
      q_r <= q_r + CNT_ONE;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pulse_frame_checker.sv
// pulse_frame_checker
// Watches the pulse generator output and checks every frame is exactly
// HI_LEN high cycles followed by at least GAP_LEN low cycles. Each good
// frame and each malformed frame is flagged with a one-cycle pulse, and
// saturating frame / error counts are kept for status readout.
// Ports:
//   clk       in  1      rising-edge clock
//   reset     in  1      synchronous active-high reset
//   y_in      in  1      pulse stream, same clock domain (no synchronizer)
//   clr_cnt   in  1      synchronous clear of both counters
//   frame_ok  out 1      pulse: valid frame completed
//   err_short out 1      pulse: high run ended before HI_LEN cycles
//   err_long  out 1      pulse: high run exceeded HI_LEN cycles
//   err_gap   out 1      pulse: low run after a good high run too short
//   busy      out 1      FSM is not in IDLE
//   frame_cnt out CNT_W  saturating count of valid frames
//   err_cnt   out CNT_W  saturating count of error pulses
module pulse_frame_checker
  import pulse_frame_pkg::*;
#(
  parameter int HI_LEN  = DEF_HI_LEN,
  parameter int GAP_LEN = DEF_GAP_LEN,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y_in,
  input  logic             clr_cnt,
  output logic             frame_ok,
  output logic             err_short,
  output logic             err_long,
  output logic             err_gap,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int RW = $clog2(HI_LEN + 1);
  localparam int GW = $clog2(GAP_LEN + 1);

  localparam logic [RW-1:0] RUN_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0] RUN_ONE  = RW'(1);
  localparam logic [RW-1:0] RUN_FULL = RW'(HI_LEN);
  localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  // gap_cnt holds lows already seen, so the current sample is the last
  // required low when gap_cnt equals GAP_LEN-1.
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);

  pf_state_t     state_r;
  pf_state_t     state_nxt_s;
  logic [RW-1:0] run_cnt_r;
  logic [RW-1:0] run_nxt_s;
  logic [GW-1:0] gap_cnt_r;
  logic [GW-1:0] gap_nxt_s;

  logic ok_nxt_s;
  logic short_nxt_s;
  logic long_nxt_s;
  logic gap_err_nxt_s;
  logic err_inc_s;

  logic frame_ok_r;
  logic err_short_r;
  logic err_long_r;
  logic err_gap_r;
  logic busy_r;

  // Next-state and next-pulse decode from the current state and y_in.
  always_comb begin
    state_nxt_s   = state_r;
    run_nxt_s     = run_cnt_r;
    gap_nxt_s     = gap_cnt_r;
    ok_nxt_s      = 1'b0;
    short_nxt_s   = 1'b0;
    long_nxt_s    = 1'b0;
    gap_err_nxt_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (y_in) begin
          state_nxt_s = ST_HIGH;
          run_nxt_s   = RUN_ONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_HIGH: begin
        if (y_in) begin
          if (run_cnt_r == RUN_FULL) begin
            long_nxt_s  = 1'b1;
            state_nxt_s = ST_RECOVER;
          end else begin
            run_nxt_s = run_cnt_r + RUN_ONE;
          end
        end else begin
          if (run_cnt_r == RUN_FULL) begin
            // With a one-cycle gap the first low already completes the frame.
            if (GAP_LEN == 1) begin
              ok_nxt_s    = 1'b1;
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_GAP;
              gap_nxt_s   = GAP_ONE;
            end
          end else begin
            short_nxt_s = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        if (y_in) begin
          // This high is taken as the first cycle of the next frame.
          gap_err_nxt_s = 1'b1;
          state_nxt_s   = ST_HIGH;
          run_nxt_s     = RUN_ONE;
        end else begin
          if (gap_cnt_r == GAP_LAST) begin
            ok_nxt_s    = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            gap_nxt_s = gap_cnt_r + GAP_ONE;
          end
        end
      end

      ST_RECOVER: begin
        // Overlong run already reported; just wait for it to end.
        if (y_in) begin
          state_nxt_s = ST_RECOVER;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        run_nxt_s   = RUN_ZERO;
        gap_nxt_s   = GAP_ZERO;
      end
    endcase
  end

  // State, run counters and registered event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      run_cnt_r   <= RUN_ZERO;
      gap_cnt_r   <= GAP_ZERO;
      frame_ok_r  <= 1'b0;
      err_short_r <= 1'b0;
      err_long_r  <= 1'b0;
      err_gap_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      run_cnt_r   <= run_nxt_s;
      gap_cnt_r   <= gap_nxt_s;
      frame_ok_r  <= ok_nxt_s;
      err_short_r <= short_nxt_s;
      err_long_r  <= long_nxt_s;
      err_gap_r   <= gap_err_nxt_s;
      // Registered copy of (state != IDLE) so busy tracks the state register.
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  // Counters are driven from the pre-register pulses so the new count lands
  // in the same cycle the pulse is visible.
  assign err_inc_s = short_nxt_s | long_nxt_s | gap_err_nxt_s;

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (ok_nxt_s),
    .q     (frame_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (err_inc_s),
    .q     (err_cnt)
  );

  assign frame_ok  = frame_ok_r;
  assign err_short = err_short_r;
  assign err_long  = err_long_r;
  assign err_gap   = err_gap_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_pulse_frame_checker.sv
// tb_pulse_frame_checker
// Directed stimulus with hand-computed expectations. Each sample that should
// produce an event pushes the expected pulse, due cycle and counter values
// into a queue; a monitor on the falling edge pops and compares whenever the
// DUT shows a pulse, and flags pulses that are missing or unexpected.
module tb_pulse_frame_checker;

  localparam int CW = 2;

  localparam logic [3:0] EV_NONE  = 4'b0000;
  localparam logic [3:0] EV_OK    = 4'b0001;
  localparam logic [3:0] EV_SHORT = 4'b0010;
  localparam logic [3:0] EV_LONG  = 4'b0100;
  localparam logic [3:0] EV_GAP   = 4'b1000;

  typedef struct {
    logic [3:0] ev;
    int         fc;
    int         ec;
    int         due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          y_in;
  logic          clr_cnt;
  logic          frame_ok;
  logic          err_short;
  logic          err_long;
  logic          err_gap;
  logic          busy;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] err_cnt;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  pulse_frame_checker #(.HI_LEN(3), .GAP_LEN(2), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .y_in      (y_in),
    .clr_cnt   (clr_cnt),
    .frame_ok  (frame_ok),
    .err_short (err_short),
    .err_long  (err_long),
    .err_gap   (err_gap),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every pulse against the head of the expectation queue.
  always @(negedge clk) begin
    logic [3:0] act;
    exp_t       e;
    act = {err_gap, err_long, err_short, frame_ok};
    if (act != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d act=%b", cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e.ev || int'(frame_cnt) != e.fc || int'(err_cnt) != e.ec || cyc != e.due) begin
          failures++;
          $display("FAIL pulse cyc=%0d act=%b fc=%0d ec=%0d | want cyc=%0d ev=%b fc=%0d ec=%0d",
                   cyc, act, frame_cnt, err_cnt, e.due, e.ev, e.fc, e.ec);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      checks++;
      failures++;
      e = exp_q.pop_front();
      $display("FAIL missing_pulse cyc=%0d act=%b want ev=%b", cyc, act, e.ev);
    end
  end

  // Drive one y_in sample; bsy is busy expected after the sampling edge.
  task automatic step(input logic y, input logic c, input logic [3:0] ev,
                      input int fc, input int ec, input logic bsy);
    exp_t e;
    y_in    = y;
    clr_cnt = c;
    if (ev != EV_NONE) begin
      e.ev  = ev;
      e.fc  = fc;
      e.ec  = ec;
      e.due = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== bsy) begin
      failures++;
      $display("FAIL busy cyc=%0d act=%b want=%b", cyc, busy, bsy);
    end
  endtask

  // Reset for one edge (y_in held at yv) and check everything reads zero.
  task automatic do_reset(input logic yv);
    reset   = 1'b1;
    y_in    = yv;
    clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({frame_ok, err_short, err_long, err_gap, busy} !== 5'b00000 ||
        frame_cnt !== 2'b00 || err_cnt !== 2'b00) begin
      failures++;
      $display("FAIL reset_state pulses=%b busy=%b fc=%0d ec=%0d want all 0",
               {err_gap, err_long, err_short, frame_ok}, busy, frame_cnt, err_cnt);
    end
  endtask

  // One clean frame 1,1,1,0,0 ending with frame_ok at count fc.
  task automatic good_frame(input logic clr_last, input int fc, input int ec);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b0, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b0, clr_last, EV_OK, fc, ec, 1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    y_in    = 1'b0;
    clr_cnt = 1'b0;
    @(posedge clk);
    #1;

    // Single frame: 0,1,1,1,0,0,0
    do_reset(1'b0);
    step(1'b0, 1'b0, EV_NONE, 0, 0, 1'b0);
    good_frame(1'b0, 1, 0);
    step(1'b0, 1'b0, EV_NONE, 0, 0, 1'b0);

    // Back-to-back frames, pulses 5 cycles apart
    do_reset(1'b0);
    good_frame(1'b0, 1, 0);
    good_frame(1'b0, 2, 0);

    // Short run 1,1,0 then a valid frame
    do_reset(1'b0);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b0, 1'b0, EV_SHORT, 0, 1, 1'b0);
    good_frame(1'b0, 1, 1);

    // Long run 1,1,1,1,1,1,0: one err_long on the 4th high
    do_reset(1'b0);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b1, 1'b0, EV_LONG, 0, 1, 1'b1);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b0, 1'b0, EV_NONE, 0, 0, 1'b0);
    step(1'b0, 1'b0, EV_NONE, 0, 0, 1'b0);

    // Short gap 1,1,1,0,1,1,1,0,0
    do_reset(1'b0);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b0, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b1, 1'b0, EV_GAP, 0, 1, 1'b1);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b0, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b0, 1'b0, EV_OK, 1, 1, 1'b0);

    // Saturation: 5 frames with a 2-bit counter stop at 3
    do_reset(1'b0);
    for (int i = 1; i <= 5; i++) begin
      good_frame(1'b0, (i > 3) ? 3 : i, 0);
    end

    // Clear coinciding with an increment wins, then counting resumes
    good_frame(1'b1, 0, 0);
    good_frame(1'b0, 1, 0);

    // Reset in the middle of a high run: no pulse, busy drops, restart clean
    do_reset(1'b0);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    step(1'b1, 1'b0, EV_NONE, 0, 0, 1'b1);
    do_reset(1'b1);
    good_frame(1'b0, 1, 0);

    // Drain and make sure nothing expected is left outstanding
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, EV_NONE, 0, 0, 1'b0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain left=%0d want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
